move_repeat: RTL and testbench

Direction-command generator between the input front-end (debounced on-board buttons and the decoded PS/2 arrow-key levels) and the player logic. It merges both sources, picks one direction by fixed priority, and emits single-cycle one-hot move pulses. A pulse fires on each fresh press, and further pulses fire while the key is held, after a hold delay, at a fixed repeat rate. A one-deep pending slot with a ready handshake ensures no press is lost while the player is busy with a map read-modify-write.

---
 rtl/move_repeat_if.sv | 19 +
 rtl/move_repeat.sv | 90 +++++++++
 tb/tb_move_repeat.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/move_repeat_if.sv
// Direction-command bus between the input front-end/bench (master) and the
// move_repeat generator (slave).
interface move_repeat_if;
   logic [3:0] btn_n;
   logic [3:0] kbd;
   logic       ready;
   logic [3:0] move;
   logic [3:0] held_dir;

   modport master (
      output btn_n, kbd, ready,
      input  move, held_dir
   );

   modport slave (
      input  btn_n, kbd, ready,
      output move, held_dir
   );
endinterface

// File: rtl/move_repeat.sv
// Merges buttons and PS/2 arrow levels into prioritized one-hot move pulses,
// with hold-delay auto-repeat and a one-deep coalescing pending slot.
module move_repeat #(
   parameter int HOLD_DELAY    = 24,
   parameter int REPEAT_PERIOD = 12
) (
   input logic          clk,
   input logic          rst,
   move_repeat_if.slave bus
);
   localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       press_p0;
   logic [3:0]       held_p1;
   logic [3:0]       slot_p1;
   logic [3:0]       move_p2;
   logic [3:0]       sel;
   logic [3:0]       ev_dir;

   // Fixed priority right > up > down > left.
   function automatic logic [3:0] pick_dir(input logic [3:0] p);
      if (p[3]) return 4'b1000;
      if (p[2]) return 4'b0100;
      if (p[1]) return 4'b0010;
      if (p[0]) return 4'b0001;
      return 4'b0000;
   endfunction

   // Stage p1: selection and event decision from the registered press levels
   always_comb begin
      sel    = pick_dir(press_p0);
      ev_dir = 4'b0000;
      if (sel != 4'b0000) begin
         if (sel != held_p1) begin
            ev_dir = sel;
         end else if ((state == DELAY  && cnt == HOLD_LAST) ||
                      (state == REPEAT && cnt == REP_LAST)) begin
            ev_dir = held_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         press_p0 <= 4'b0000;
         held_p1  <= 4'b0000;
         slot_p1  <= 4'b0000;
         move_p2  <= 4'b0000;
         cnt      <= '0;
         state    <= IDLE;
      end else begin
         // Stage p0: merge both sources, active-low buttons inverted
         press_p0 <= bus.kbd | ~bus.btn_n;
         held_p1  <= sel;

         if (sel == 4'b0000) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (sel != held_p1) begin
            state <= DELAY;
            cnt   <= '0;
         end else if (state == DELAY && cnt == HOLD_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
         end else if (state == REPEAT && cnt == REP_LAST) begin
            cnt   <= '0;
         end else begin
            cnt   <= cnt + CNT_W'(1);
         end

         // Stage p2: drain the slot; a same-cycle event refills it (latest wins)
         move_p2 <= (bus.ready && slot_p1 != 4'b0000) ? slot_p1 : 4'b0000;
         if (ev_dir != 4'b0000) begin
            slot_p1 <= ev_dir;
         end else if (bus.ready) begin
            slot_p1 <= 4'b0000;
         end
      end
   end

   assign bus.move     = move_p2;
   assign bus.held_dir = held_p1;
endmodule

// File: tb/tb_move_repeat.sv
// Directed checks of move_repeat timing, priority, coalescing and reset,
// plus randomized traffic compared cycle by cycle against a reference model.
module tb_move_repeat;
   localparam int HD = 8;
   localparam int RP = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   move_repeat_if bus();

   move_repeat #(.HOLD_DELAY(HD), .REPEAT_PERIOD(RP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int pt[$];
   logic [3:0] pd[$];
   int et[8];
   logic [3:0] ed[8];

   // Reference model: age counts edges since the last fresh selection.
   logic [3:0] m_press = '0, m_held = '0, m_slot = '0, m_move = '0;
   logic [3:0] m_s, m_e;
   int m_age = 0, m_age_n;
   bit rnd_on = 1'b0;
   int seq_err = 0, oh_err = 0, dut_pulses = 0, mdl_pulses = 0;

   function automatic logic [3:0] prio(input logic [3:0] p);
      if (p[3]) return 4'b1000;
      if (p[2]) return 4'b0100;
      if (p[1]) return 4'b0010;
      if (p[0]) return 4'b0001;
      return 4'b0000;
   endfunction

   always_comb begin
      m_s     = prio(m_press);
      m_e     = 4'b0000;
      m_age_n = m_age + 1;
      if (m_s != 4'b0000 && m_s != m_held)
         m_e = m_s;
      else if (m_s != 4'b0000 &&
               (m_age_n == HD || (m_age_n > HD && ((m_age_n - HD) % RP) == 0)))
         m_e = m_held;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_press <= '0; m_held <= '0; m_slot <= '0; m_move <= '0; m_age <= 0;
      end else begin
         m_age   <= (m_s == 4'b0000 || m_s != m_held) ? 0 : m_age_n;
         m_move  <= (bus.ready && m_slot != 4'b0000) ? m_slot : 4'b0000;
         m_slot  <= (m_e != 4'b0000) ? m_e : (bus.ready ? 4'b0000 : m_slot);
         m_press <= bus.kbd | ~bus.btn_n;
         m_held  <= m_s;
      end
   end

   always @(negedge clk) begin
      if (bus.move != 4'b0000) begin
         pt.push_back(cyc);
         pd.push_back(bus.move);
      end
      cyc <= cyc + 1;
      if (rnd_on) begin
         if (bus.move !== m_move) seq_err <= seq_err + 1;
         if (!$onehot0(bus.move)) oh_err <= oh_err + 1;
         if (bus.move != 4'b0000) dut_pulses <= dut_pulses + 1;
         if (m_move != 4'b0000) mdl_pulses <= mdl_pulses + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_pulses(input string tag, input int c0, input int n);
      chk({tag, ".count"}, pt.size(), n);
      for (int i = 0; i < n && i < pt.size(); i++) begin
         chk($sformatf("%s.t%0d", tag, i), pt[i] - c0, et[i]);
         chk($sformatf("%s.d%0d", tag, i), 32'(pd[i]), 32'(ed[i]));
      end
   endtask

   initial begin
      int c0;
      int hold;
      rst = 1'b1;
      bus.kbd = 4'b0000;
      bus.btn_n = 4'b1111;
      bus.ready = 1'b1;
      step(3);
      chk("reset.move", 32'(bus.move), 32'h0);
      chk("reset.held", 32'(bus.held_dir), 32'h0);
      rst = 1'b0;
      step(3);

      // 1: single tap of up
      pt.delete(); pd.delete(); c0 = cyc;
      bus.kbd = 4'b0100; step(1); bus.kbd = 4'b0000; step(20);
      et = '{3, 0, 0, 0, 0, 0, 0, 0};
      ed = '{4'b0100, 0, 0, 0, 0, 0, 0, 0};
      expect_pulses("tap", c0, 1);

      // 2: hold left 30 cycles
      pt.delete(); pd.delete(); c0 = cyc;
      bus.btn_n = 4'b1110; step(30); bus.btn_n = 4'b1111; step(20);
      et = '{3, 11, 15, 19, 23, 27, 31, 0};
      ed = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0};
      expect_pulses("hold", c0, 7);

      // 3: right beats left; releasing right gives a fresh left pulse
      pt.delete(); pd.delete(); c0 = cyc;
      bus.kbd = 4'b0001; bus.btn_n = 4'b0111; step(2);
      chk("prio.held", 32'(bus.held_dir), 32'h8);
      step(4); bus.btn_n = 4'b1111; step(20); bus.kbd = 4'b0000; step(15);
      et = '{3, 9, 17, 21, 25, 0, 0, 0};
      ed = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0};
      expect_pulses("prio", c0, 5);

      // 4: ready low, up then down coalesce to a single down pulse
      pt.delete(); pd.delete(); c0 = cyc;
      bus.ready = 1'b0;
      bus.kbd = 4'b0100; step(1); bus.kbd = 4'b0000; step(4);
      bus.kbd = 4'b0010; step(1); bus.kbd = 4'b0000; step(9);
      bus.ready = 1'b1; step(10);
      et = '{16, 0, 0, 0, 0, 0, 0, 0};
      ed = '{4'b0010, 0, 0, 0, 0, 0, 0, 0};
      expect_pulses("coal", c0, 1);

      // 5: reset mid-repeat while holding right
      pt.delete(); pd.delete(); c0 = cyc;
      bus.btn_n = 4'b0111; step(14);
      rst = 1'b1; step(1); rst = 1'b0;
      chk("midrst.move", 32'(bus.move), 32'h0);
      chk("midrst.held", 32'(bus.held_dir), 32'h0);
      step(25); bus.btn_n = 4'b1111; step(10);
      et = '{3, 11, 18, 26, 30, 34, 38, 42};
      ed = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
      expect_pulses("midrst", c0, 8);

      // 6: randomized press/ready traffic
      rst = 1'b1; step(1); rst = 1'b0;
      rnd_on = 1'b1;
      hold = 0;
      for (int i = 0; i < 10000; i++) begin
         if (hold == 0) begin
            bus.kbd   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            bus.btn_n = ($urandom_range(0, 2) == 0) ? ~4'($urandom) : 4'b1111;
            hold = $urandom_range(1, 40);
         end
         hold--;
         bus.ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      step(1);
      rnd_on = 1'b0;
      step(1);
      chk("rnd.seq", seq_err, 0);
      chk("rnd.onehot", oh_err, 0);
      chk("rnd.count", dut_pulses, mdl_pulses);
      chk("rnd.active", 32'(dut_pulses > 0), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
